jogador_automatico: RTL and testbench

- Autonomous player for the memory game (circuito_exp5 family). It sits on the opposite side of the game's leds/chaves interface from the game core.
- It watches the sequence the game shows on leds and stores it. When the game hands control to the player, it replays the sequence on chaves with fixed press/release timing.
- Used on the board and in benches to run full games without a human.

---
 rtl/jogador_automatico.sv | 179 +++++++++++++++++
 tb/tb_jogador_automatico.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// Autonomous memory-game player: captures the sequence shown on leds and replays it on chaves.
// Optional deliberate-error replay is enabled with the JOGADOR_ERRO_PROPOSITAL_EN macro.
module jogador_automatico #(
   parameter int MAX_JOGADAS = 16,
   parameter int ADDR_W      = 4,
   parameter int T_PRESS     = 5,
   parameter int T_SOLTA     = 5
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
   ,
   parameter int ERRO_RODADA = 3
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              habilitar,
   input  logic [3:0]        leds,
   input  logic              vez_jogador,
   input  logic              acertou,
   input  logic              errou,
   output logic [3:0]        chaves,
   output logic              ocupado,
   output logic [ADDR_W:0]   num_jogadas,
   output logic              erro_captura,
   output logic [3:0]        db_estado
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      CAPTURA    = 4'd1,
      PRESSIONA  = 4'd2,
      SOLTA      = 4'd3,
      PROXIMA    = 4'd4,
      FIM_RODADA = 4'd5,
      PARADO     = 4'd6
   } estado_t;

   localparam int TW = $clog2(T_PRESS + T_SOLTA + 1);

   estado_t           estado;
   logic [3:0]        leds_r;
   logic [3:0]        leds_ant;
   logic [3:0]        mem [MAX_JOGADAS];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [TW-1:0]     timer;
   logic [3:0]        chaves_r;
   logic              ocupado_r;
   logic              erro_r;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
   logic [7:0]        rodada;
`endif

   logic              evento;
   logic              one_hot;
   logic              cheio;
   logic              grava;
   logic              aborta;
   logic [ADDR_W:0]   wr_ptr_nx;
   logic [ADDR_W:0]   rd_prox;
   logic [3:0]        mem_dado;
   logic [3:0]        jogada;

   always_comb begin
      evento    = (estado == CAPTURA) && (leds_ant == 4'b0000) && (leds_r != 4'b0000);
      one_hot   = (leds_r != 4'b0000) && ((leds_r & (leds_r - 4'd1)) == 4'b0000);
      cheio     = (wr_ptr == (ADDR_W+1)'(MAX_JOGADAS));
      aborta    = (estado != IDLE) && (acertou || errou);
      grava     = evento && one_hot && !cheio && habilitar && !aborta;
      wr_ptr_nx = grava ? wr_ptr + 1'b1 : wr_ptr;
      rd_prox   = rd_ptr + 1'b1;
      mem_dado  = mem[rd_ptr[ADDR_W-1:0]];
      jogada    = mem_dado;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
      if (rodada == 8'(ERRO_RODADA) && rd_prox == wr_ptr)
         jogada = {mem_dado[2:0], mem_dado[3]};
`endif
   end

   always_ff @(posedge clock) begin
      if (grava)
         mem[wr_ptr[ADDR_W-1:0]] <= leds_r;
   end

   // chaves_r lags the state by one cycle, so SOLTA plus PROXIMA give the T_PRESS+T_SOLTA+1 spacing.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado    <= IDLE;
         leds_r    <= '0;
         leds_ant  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         timer     <= '0;
         chaves_r  <= '0;
         ocupado_r <= 1'b0;
         erro_r    <= 1'b0;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
         rodada    <= '0;
`endif
      end else begin
         leds_r   <= leds;
         leds_ant <= leds_r;
         chaves_r <= '0;
         if (!habilitar) begin
            estado    <= IDLE;
            ocupado_r <= 1'b0;
         end else if (aborta) begin
            estado    <= PARADO;
            ocupado_r <= 1'b0;
         end else begin
            case (estado)
               IDLE: begin
                  estado <= CAPTURA;
                  wr_ptr <= '0;
                  erro_r <= 1'b0;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
                  rodada <= 8'd1;
`endif
               end
               CAPTURA: begin
                  wr_ptr <= wr_ptr_nx;
                  if (evento && !grava)
                     erro_r <= 1'b1;
                  if (vez_jogador && wr_ptr_nx != '0) begin
                     estado    <= PRESSIONA;
                     rd_ptr    <= '0;
                     timer     <= '0;
                     ocupado_r <= 1'b1;
                  end
               end
               PRESSIONA: begin
                  chaves_r <= jogada;
                  if (timer == TW'(T_PRESS - 1)) begin
                     estado <= SOLTA;
                     timer  <= '0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               SOLTA: begin
                  if (timer == TW'(T_SOLTA - 1)) begin
                     estado    <= PROXIMA;
                     timer     <= '0;
                     ocupado_r <= 1'b0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               PROXIMA: begin
                  rd_ptr <= rd_prox;
                  if (rd_prox == wr_ptr) begin
                     estado <= FIM_RODADA;
                  end else begin
                     estado    <= PRESSIONA;
                     timer     <= '0;
                     ocupado_r <= 1'b1;
                  end
               end
               FIM_RODADA: begin
                  wr_ptr <= '0;
                  estado <= CAPTURA;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
                  if (rodada != 8'hFF)
                     rodada <= rodada + 8'd1;
`endif
               end
               PARADO: estado <= PARADO;
               default: estado <= IDLE;
            endcase
         end
      end
   end

   assign chaves       = (habilitar && !aborta) ? chaves_r : 4'b0000;
   assign ocupado      = ocupado_r;
   assign num_jogadas  = wr_ptr;
   assign erro_captura = erro_r;
   assign db_estado    = estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: capture, replay timing, capture errors, abort and async reset.
module tb_jogador_automatico;

   logic        clock = 1'b0;
   logic        reset;
   logic        habilitar;
   logic [3:0]  leds;
   logic        vez_jogador;
   logic        acertou;
   logic        errou;
   logic [3:0]  chaves;
   logic        ocupado;
   logic [4:0]  num_jogadas;
   logic        erro_captura;
   logic [3:0]  db_estado;

   int errors = 0;
   int checks = 0;

   jogador_automatico dut (
      .clock        (clock),
      .reset        (reset),
      .habilitar    (habilitar),
      .leds         (leds),
      .vez_jogador  (vez_jogador),
      .acertou      (acertou),
      .errou        (errou),
      .chaves       (chaves),
      .ocupado      (ocupado),
      .num_jogadas  (num_jogadas),
      .erro_captura (erro_captura),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic show(input logic [3:0] v, input int on, input int off);
      leds = v;
      repeat (on) @(negedge clock);
      leds = 4'b0000;
      repeat (off) @(negedge clock);
   endtask

   // Leaves the bench at the negedge of the PRESSIONA entry cycle.
   task automatic pulse_vez();
      vez_jogador = 1'b1;
      @(negedge clock);
      vez_jogador = 1'b0;
   endtask

   // seq holds up to four jogadas, first one in bits [3:0].
   task automatic replay(input string tag, input logic [15:0] seq, input int n);
      logic [3:0] v;
      check({tag, "_entry_state"}, db_estado, 4'd2);
      check({tag, "_entry_chaves"}, chaves, 4'b0000);
      for (int j = 0; j < n; j++) begin
         v = seq[4*j +: 4];
         for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check({tag, "_press"}, chaves, v);
            check({tag, "_ocupado"}, ocupado, 1'b1);
         end
         for (int k = 0; k < ((j == n - 1) ? 5 : 6); k++) begin
            @(negedge clock);
            check({tag, "_solta"}, chaves, 4'b0000);
         end
      end
      @(negedge clock);
      check({tag, "_fim_rodada"}, db_estado, 4'd5);
      @(negedge clock);
      check({tag, "_captura"}, db_estado, 4'd1);
      check({tag, "_num_zero"}, num_jogadas, 5'd0);
   endtask

   initial begin
      reset = 1'b0;
      habilitar = 1'b0;
      leds = 4'b0000;
      vez_jogador = 1'b0;
      acertou = 1'b0;
      errou = 1'b0;
      #3;
      check("rst_chaves", chaves, 4'b0000);
      check("rst_state", db_estado, 4'd0);
      check("rst_num", num_jogadas, 5'd0);
      check("rst_erro", erro_captura, 1'b0);
      check("rst_ocupado", ocupado, 1'b0);

      @(negedge clock);
      reset = 1'b1;
      habilitar = 1'b1;
      @(negedge clock);
      check("idle_to_captura", db_estado, 4'd1);

      // Round 1: single jogada
      show(4'b0001, 3, 2);
      check("r1_num", num_jogadas, 5'd1);
      pulse_vez();
      replay("r1", 16'h0001, 1);

      // Round 2: four jogadas
      show(4'b0001, 3, 2);
      show(4'b0010, 3, 2);
      show(4'b0100, 3, 2);
      show(4'b1000, 3, 2);
      check("r2_num", num_jogadas, 5'd4);
      pulse_vez();
      replay("r2", 16'h8421, 4);

      // Round 3: last jogada rotated when the deliberate-error option is built in
      show(4'b0001, 3, 2);
      show(4'b0010, 3, 2);
      show(4'b0100, 3, 2);
      check("r3_num", num_jogadas, 5'd3);
      pulse_vez();
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
      replay("r3", 16'h0821, 3);
`else
      replay("r3", 16'h0421, 3);
`endif

      // Capture overflow: 16 fit, the 17th is dropped
      for (int i = 0; i < 16; i++)
         show(4'b0001 << (i % 4), 2, 1);
      check("ovf_num16", num_jogadas, 5'd16);
      check("ovf_erro_before", erro_captura, 1'b0);
      show(4'b0100, 2, 1);
      check("ovf_num_held", num_jogadas, 5'd16);
      check("ovf_erro", erro_captura, 1'b1);

      // erro_captura clears on IDLE -> CAPTURA
      habilitar = 1'b0;
      @(negedge clock);
      check("dis_idle", db_estado, 4'd0);
      check("dis_erro_sticky", erro_captura, 1'b1);
      habilitar = 1'b1;
      @(negedge clock);
      check("reen_captura", db_estado, 4'd1);
      check("reen_erro_clear", erro_captura, 1'b0);
      check("reen_num", num_jogadas, 5'd0);

      // Non-one-hot leds
      show(4'b0011, 3, 2);
      check("nonhot_erro", erro_captura, 1'b1);
      check("nonhot_num", num_jogadas, 5'd0);
      show(4'b0100, 3, 2);
      check("after_nonhot_num", num_jogadas, 5'd1);

      // errou mid-PRESSIONA
      pulse_vez();
      @(negedge clock);
      @(negedge clock);
      check("ab_press_active", chaves, 4'b0100);
      errou = 1'b1;
      #1;
      check("ab_chaves_now", chaves, 4'b0000);
      @(negedge clock);
      check("ab_parado", db_estado, 4'd6);
      check("ab_chaves_parado", chaves, 4'b0000);
      errou = 1'b0;
      @(negedge clock);
      check("ab_parado_hold", db_estado, 4'd6);
      check("ab_parado_chaves", chaves, 4'b0000);
      habilitar = 1'b0;
      @(negedge clock);
      check("ab_idle", db_estado, 4'd0);

      // Asynchronous reset mid-SOLTA
      habilitar = 1'b1;
      @(negedge clock);
      check("rs_captura", db_estado, 4'd1);
      show(4'b0010, 3, 2);
      check("rs_num", num_jogadas, 5'd1);
      pulse_vez();
      repeat (7) @(negedge clock);
      check("rs_solta", db_estado, 4'd3);
      check("rs_num_replay", num_jogadas, 5'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rs_async_chaves", chaves, 4'b0000);
      check("rs_async_num", num_jogadas, 5'd0);
      check("rs_async_state", db_estado, 4'd0);
      check("rs_async_ocupado", ocupado, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
